// File: rtl/sysram_uart_pkg.sv
// Shared types and constants for the system-RAM to UART reader.
// The checksum frame layout lives here so the bench and RTL agree.
package sysram_uart_pkg;

   localparam int          ADDR_W_DEF = 16;
   localparam logic [15:0] CHK_TAG    = 16'hC5C5;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      SEND,
      DONE
   } state_t;

   function automatic logic [63:0] chk_frame(
      input logic [15:0] cnt,
      input logic [63:0] x
   );
      return {CHK_TAG, cnt, x[63:32] ^ x[31:0]};
   endfunction

endpackage

// File: rtl/sysram_uart_reader_if.sv
// Control, RAM read port and TX handshake bundle of the reader.
// master = reader side, slave = RAM/UART/control side.
interface sysram_uart_reader_if
   import sysram_uart_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              I_start;
   logic              I_abort;
   logic [ADDR_W-1:0] I_base_addr;
   logic [ADDR_W-1:0] I_len;
   logic [ADDR_W-1:0] O_ram_addr;
   logic              O_ram_rd_en;
   logic [31:0]       I_ram_data;
   logic [63:0]       O_tx_data;
   logic              O_tx_en;
   logic              I_tx_ready;
   logic              O_busy;
   logic              O_done;
   logic [ADDR_W-1:0] O_frame_cnt;

   modport master (
      input  I_start, I_abort, I_base_addr, I_len,
      input  I_ram_data, I_tx_ready,
      output O_ram_addr, O_ram_rd_en, O_tx_data,
      output O_tx_en, O_busy, O_done, O_frame_cnt
   );

   modport slave (
      output I_start, I_abort, I_base_addr, I_len,
      output I_ram_data, I_tx_ready,
      input  O_ram_addr, O_ram_rd_en, O_tx_data,
      input  O_tx_en, O_busy, O_done, O_frame_cnt
   );

endinterface

// File: rtl/sysram_rd_lat.sv
// Delays the RAM read strobe by RAM_LAT cycles to mark when
// read data is valid for capture.
module sysram_rd_lat #(
   parameter int RAM_LAT = 1
) (
   input  logic I_clk,
   input  logic I_rst,
   input  logic I_rd_en,
   output logic O_cap
);

   logic [RAM_LAT-1:0] sr_q;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         sr_q <= '0;
      end else begin
         sr_q[0] <= I_rd_en;
         for (int i = 1; i < RAM_LAT; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   assign O_cap = sr_q[RAM_LAT-1];

endmodule

// File: rtl/sysram_uart_reader.sv
// Streams RAM word pairs as 64-bit frames to the UART TX.
// Define SYSRAM_RD_CHECKSUM_EN to append an XOR checksum frame.
module sysram_uart_reader
   import sysram_uart_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int RAM_LAT = 1
) (
   input logic                  I_clk,
   input logic                  I_rst,
   sysram_uart_reader_if.master bus
);

   state_t            state_q, state_d;
   logic              issued_q, issued_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [63:0]       data_q, data_d;
   logic              abort_q, abort_d;
   logic              rd_en, cap, hs, chk_now;

`ifdef SYSRAM_RD_CHECKSUM_EN
   logic [63:0] xor_q, xor_d;
   logic        chk_q, chk_d;
   assign chk_now = chk_q;
`else
   assign chk_now = 1'b0;
`endif

   sysram_rd_lat #(.RAM_LAT(RAM_LAT)) u_lat (
      .I_clk   (I_clk),
      .I_rst   (I_rst),
      .I_rd_en (rd_en),
      .O_cap   (cap)
   );

   assign hs = (state_q == SEND) && bus.I_tx_ready;

   always_comb begin
      state_d  = state_q;
      issued_d = issued_q;
      ptr_d    = ptr_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      rd_en    = 1'b0;
      abort_d  = abort_q;
`ifdef SYSRAM_RD_CHECKSUM_EN
      xor_d    = xor_q;
      chk_d    = chk_q;
`endif
      if (state_q != IDLE) abort_d = abort_q | bus.I_abort;

      unique case (state_q)
         IDLE: begin
            if (bus.I_start && !bus.I_abort) begin
               ptr_d    = bus.I_base_addr;
               rem_d    = bus.I_len;
               cnt_d    = '0;
               issued_d = 1'b0;
               abort_d  = 1'b0;
`ifdef SYSRAM_RD_CHECKSUM_EN
               xor_d    = '0;
               chk_d    = 1'b0;
`endif
               state_d  = (bus.I_len == '0) ? DONE : RD_LO;
            end
         end
         RD_LO: begin
            rd_en = !issued_q;
            if (!issued_q) issued_d = 1'b1;
            if (cap) begin
               data_d[31:0] = bus.I_ram_data;
               ptr_d        = ptr_q + 1'b1;
               issued_d     = 1'b0;
               // an abort here drops the half-read frame
               state_d      = abort_d ? DONE : RD_HI;
            end
         end
         RD_HI: begin
            rd_en = !issued_q;
            if (!issued_q) issued_d = 1'b1;
            if (cap) begin
               data_d[63:32] = bus.I_ram_data;
               ptr_d         = ptr_q + 1'b1;
               issued_d      = 1'b0;
               state_d       = SEND;
            end
         end
         SEND: begin
            if (hs && !chk_now) begin
               cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
               rem_d = rem_q - 1'b1;
               if (rem_q == ADDR_W'(1) || abort_d) state_d = DONE;
               else state_d = RD_LO;
`ifdef SYSRAM_RD_CHECKSUM_EN
               xor_d = xor_q ^ data_q;
               if (rem_q == ADDR_W'(1) && !abort_d) begin
                  chk_d   = 1'b1;
                  data_d  = chk_frame(16'(cnt_d), xor_d);
                  state_d = SEND;
               end
`endif
            end
`ifdef SYSRAM_RD_CHECKSUM_EN
            if (hs && chk_q) begin
               chk_d   = 1'b0;
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            abort_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q  <= IDLE;
         issued_q <= 1'b0;
         ptr_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         abort_q  <= 1'b0;
`ifdef SYSRAM_RD_CHECKSUM_EN
         xor_q    <= '0;
         chk_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         ptr_q    <= ptr_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         abort_q  <= abort_d;
`ifdef SYSRAM_RD_CHECKSUM_EN
         xor_q    <= xor_d;
         chk_q    <= chk_d;
`endif
      end
   end

   assign bus.O_ram_addr  = ptr_q;
   assign bus.O_ram_rd_en = rd_en;
   assign bus.O_tx_data   = data_q;
   assign bus.O_tx_en     = (state_q == SEND);
   assign bus.O_busy      = (state_q != IDLE);
   assign bus.O_done      = (state_q == DONE);
   assign bus.O_frame_cnt = cnt_q;

endmodule
